access_request_ctrl: RTL and testbench
======================================

// Module: access_request_ctrl
// PURPOSE
// - Initiator side of the access-control request interface: collects four 4-bit digits, packs them into a
//   16-bit password, issues a LOGIN request, and waits for the responder's status frame.
// - Drives the grant/deny LEDs, issues LOGOUT, and enforces a lockout after repeated failures.
// - Sits between the debounced keypad/switch front end and the access-control comparator.
// PARAMETERS
// - MAX_FAILS       3     consecutive denials (or timeouts) that trigger lockout; range 1..15
// - TIMEOUT_CYCLES  255   maximum WAIT cycles before the request counts as denied; >=2
// - LOCKOUT_CYCLES  1000  cycles spent in LOCKED before returning to IDLE; >=1
// PORTS
// - clk            in   1   system clock
// - rst            in   1   synchronous, active-high reset
// - digit_in       in   4   digit value, sampled when digit_load=1
// - digit_load     in   1   one-cycle pulse, digit_in valid
// - logout_req     in   1   one-cycle pulse, user requests logout
// - req_out        out  2   request code: 00 NONE, 01 LOGIN, 10 LOGOUT, 11 reserved (never driven)
// - data_out       out  16  packed password; first digit in [15:12], fourth in [3:0]
// - data_load_out  out  1   one-cycle pulse, req_out/data_out valid
// - status_in      in   2   responder frame: 00 PENDING, 01 GRANTED, 10 DENIED, 11 reserved
// - access_granted out  1   high while in GRANTED
// - led_green      out  1   equals access_granted
// - led_red        out  1   high in DENIED and LOCKED
// - locked         out  1   high in LOCKED
// - digit_count    out  3   digits collected so far, 0..4
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; shift register, fail counter, timers cleared. Reset mid-operation
//   aborts everything with no LOGOUT issued.
// - IDLE: on digit_load, shift reg <= {reg[11:0],digit_in} and digit_count++. When the 4th digit loads,
//   go to SEND on the next edge; digit_count reads 4 for that one cycle.
// - SEND (1 cycle): req_out=01, data_out=packed, data_load_out=1. Next state: WAIT. Clear digit_count.
// - WAIT: req_out=01 and data_out held, data_load_out=0, timer counts from 1.
//   - status 01 -> GRANTED, fail counter cleared.
//   - status 10, or timer reaching TIMEOUT_CYCLES -> DENIED.
//   - status 00 or 11 -> stay in WAIT.
// - DENIED (1 cycle, led_red=1): fail_cnt++. If the new count equals MAX_FAILS, go to LOCKED; otherwise
//   go to IDLE.
// - LOCKED: led_red=1, locked=1, timer counts LOCKOUT_CYCLES. Then go to IDLE with fail_cnt=0.
// - GRANTED: access_granted=1, led_green=1 until logout_req.
// - LOGOUT (1 cycle): req_out=10, data_out=0, data_load_out=1. Next state: IDLE.
// - req_out=00 and data_out=0 in IDLE, DENIED, LOCKED and GRANTED.
// - digit_load is ignored outside IDLE, so no digit is buffered. logout_req is ignored outside GRANTED.
// - A digit_load coinciding with the 4th-digit transition cannot occur, because SEND is a separate state.
// - All outputs are registered; status_in is sampled directly with no synchronizer (same clock domain).
// CONFIGURATION
// - CLEAR_KEY_EN defined: in IDLE, digit_load with digit_in==4'hF clears the shift register and
//   digit_count. The value is not stored and does not advance the count.
// - CLEAR_KEY_EN undefined: 4'hF is an ordinary digit.
// TESTING
// - Load digits 1,2,3,4, responder returns 01 after 3 cycles -> one SEND pulse with data_out=16'h1234,
//   req=01; access_granted=1.
// - Then pulse logout_req -> one cycle with req=10, data_load_out=1, data=0; back to IDLE, LEDs off.
// - Three wrong entries each answered 10 (MAX_FAILS=3) -> led_red pulses, then locked=1 for exactly
//   1000 cycles; a digit_load during lockout leaves digit_count at 0.
// - Responder never answers -> DENIED exactly TIMEOUT_CYCLES cycles after SEND; fail_cnt=1.
// - status 11 for 5 cycles, then 01 -> stays in WAIT, then GRANTED; a grant after 2 failures clears
//   fail_cnt.
// - CLEAR_KEY_EN: load 1,2,F,5,6,7,8 -> data_out=16'h5678. Without the macro, load 1,2,F,5 ->
//   data_out=16'h12F5.

Source files
------------

// File: rtl/access_request_ctrl_if.sv
// Request/status bus between the access-request initiator and the access-control responder.
interface access_request_ctrl_if;
  logic [1:0]  req_out;
  logic [15:0] data_out;
  logic        data_load_out;
  logic [1:0]  status_in;

  modport master (output req_out, output data_out, output data_load_out, input status_in);
  modport slave  (input req_out, input data_out, input data_load_out, output status_in);
endinterface

// File: rtl/access_request_ctrl.sv
// Access-request initiator: packs four keypad digits, issues LOGIN/LOGOUT and enforces failure lockout.
// Optional CLEAR_KEY_EN: digit 4'hF in IDLE clears the partially entered password.
module access_request_ctrl #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   digit_in,
  input  logic                         digit_load,
  input  logic                         logout_req,
  access_request_ctrl_if.master        bus,
  output logic                         access_granted,
  output logic                         led_green,
  output logic                         led_red,
  output logic                         locked,
  output logic [2:0]                   digit_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DENIED  = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;
  localparam logic [2:0] S_GRANTED = 3'd5;
  localparam logic [2:0] S_LOGOUT  = 3'd6;

  localparam int unsigned TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  logic [2:0]    state, nxt;
  logic [15:0]   shift_reg;
  logic [3:0]    fail_cnt;
  logic [TW-1:0] timer;
  logic          accept;
  logic          clear_key;

  always_comb begin
`ifdef CLEAR_KEY_EN
    clear_key = (digit_in == 4'hF);
`else
    clear_key = 1'b0;
`endif
    accept = (state == S_IDLE) && digit_load && (digit_count != 3'd4);
  end

  // WAIT starts its timer at 1, so leaving at TIMEOUT_CYCLES-1 puts DENIED exactly TIMEOUT_CYCLES after SEND
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (digit_count == 3'd4) nxt = S_SEND;
      S_SEND:    nxt = S_WAIT;
      S_WAIT: begin
        if (bus.status_in == 2'b01)
          nxt = S_GRANTED;
        else if (bus.status_in == 2'b10 || timer == TW'(TIMEOUT_CYCLES - 1))
          nxt = S_DENIED;
      end
      S_DENIED:  nxt = (fail_cnt + 4'd1 == 4'(MAX_FAILS)) ? S_LOCKED : S_IDLE;
      S_LOCKED:  if (timer == TW'(LOCKOUT_CYCLES)) nxt = S_IDLE;
      S_GRANTED: if (logout_req) nxt = S_LOGOUT;
      S_LOGOUT:  nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      shift_reg         <= '0;
      digit_count       <= '0;
      fail_cnt          <= '0;
      timer             <= '0;
      bus.req_out       <= '0;
      bus.data_out      <= '0;
      bus.data_load_out <= 1'b0;
      access_granted    <= 1'b0;
      led_green         <= 1'b0;
      led_red           <= 1'b0;
      locked            <= 1'b0;
    end else begin
      state <= nxt;

      if (nxt == S_SEND) begin
        digit_count <= '0;
      end else if (accept) begin
        if (clear_key) begin
          shift_reg   <= '0;
          digit_count <= '0;
        end else begin
          shift_reg   <= {shift_reg[11:0], digit_in};
          digit_count <= digit_count + 3'd1;
        end
      end

      if (nxt == S_WAIT || nxt == S_LOCKED)
        timer <= (nxt == state) ? timer + TW'(1) : TW'(1);
      else
        timer <= '0;

      if (state == S_WAIT && nxt == S_GRANTED)
        fail_cnt <= '0;
      else if (state == S_DENIED)
        fail_cnt <= fail_cnt + 4'd1;
      else if (state == S_LOCKED && nxt == S_IDLE)
        fail_cnt <= '0;

      bus.req_out       <= (nxt == S_SEND || nxt == S_WAIT) ? 2'b01 :
                           (nxt == S_LOGOUT)                ? 2'b10 : 2'b00;
      bus.data_out      <= (nxt == S_SEND) ? shift_reg :
                           (nxt == S_WAIT) ? bus.data_out : '0;
      bus.data_load_out <= (nxt == S_SEND) || (nxt == S_LOGOUT);
      access_granted    <= (nxt == S_GRANTED);
      led_green         <= (nxt == S_GRANTED);
      led_red           <= (nxt == S_DENIED) || (nxt == S_LOCKED);
      locked            <= (nxt == S_LOCKED);
    end
  end

endmodule

// File: tb/tb_access_request_ctrl.sv
// Scoreboard bench for access_request_ctrl: stimulus queues expected request frames, a monitor checks them.
module tb_access_request_ctrl;
  localparam int unsigned MF = 3;
  localparam int unsigned TO = 255;
  localparam int unsigned LO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_load = 1'b0;
  logic       logout_req = 1'b0;
  logic       access_granted, led_green, led_red, locked;
  logic [2:0] digit_count;

  access_request_ctrl_if bus();

  access_request_ctrl #(
    .MAX_FAILS(MF),
    .TIMEOUT_CYCLES(TO),
    .LOCKOUT_CYCLES(LO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digit_in(digit_in),
    .digit_load(digit_load),
    .logout_req(logout_req),
    .bus(bus),
    .access_granted(access_granted),
    .led_green(led_green),
    .led_red(led_red),
    .locked(locked),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [17:0] exp_q[$];
  logic [15:0] last_login = '0;
  logic [17:0] mon_e;
  int          lock_n;
  int          to_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frames are {req, data}; LOGIN data must also hold steady through WAIT
  always @(negedge clk) begin
    if (bus.data_load_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_load: got req=%0d data=%0h expected no load", bus.req_out, bus.data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("load_frame", {14'd0, bus.req_out, bus.data_out}, {14'd0, mon_e});
        if (mon_e[17:16] == 2'b01) last_login = mon_e[15:0];
      end
    end else if (bus.req_out === 2'b01) begin
      check("wait_hold", {14'd0, bus.req_out, bus.data_out}, {14'd0, 2'b01, last_login});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] d);
    digit_in   = d;
    digit_load = 1'b1;
    tick();
    digit_load = 1'b0;
  endtask

  // Leaves the bench in the SEND cycle
  task automatic enter(input logic [15:0] pw);
    exp_q.push_back({2'b01, pw});
    for (int i = 3; i >= 0; i--) begin
      load_digit(pw[i*4 +: 4]);
      if (i == 3) check("count_first", {29'd0, digit_count}, 32'd1);
    end
    check("count_full", {29'd0, digit_count}, 32'd4);
    tick();
    check("count_cleared_send", {29'd0, digit_count}, 32'd0);
  endtask

  task automatic deny_entry(input logic [15:0] pw);
    enter(pw);
    bus.status_in = 2'b10;
    tick();
    tick();
    bus.status_in = 2'b00;
    check("denied_leds", {30'd0, led_red, locked}, 32'b10);
    tick();
  endtask

  task automatic do_logout();
    exp_q.push_back({2'b10, 16'h0000});
    logout_req = 1'b1;
    tick();
    logout_req = 1'b0;
    check("logout_leds", {30'd0, access_granted, led_green}, 32'd0);
    tick();
    check("idle_after_logout", {26'd0, access_granted, led_green, led_red, locked, bus.req_out}, 32'd0);
  endtask

  initial begin
    bus.status_in = 2'b00;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {8'd0, access_granted, led_green, led_red, locked, digit_count,
                            bus.req_out, bus.data_out, bus.data_load_out}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic login: grant arrives in the third WAIT cycle
    enter(16'h1234);
    tick();
    tick();
    check("not_yet_granted", {31'd0, access_granted}, 32'd0);
    bus.status_in = 2'b01;
    tick();
    bus.status_in = 2'b00;
    check("granted_leds", {28'd0, access_granted, led_green, led_red, locked}, 32'b1100);
    check("granted_req_none", {30'd0, bus.req_out}, 32'd0);
    repeat (3) tick();
    check("granted_held", {31'd0, access_granted}, 32'd1);
    do_logout();

    // logout_req outside GRANTED must not produce a frame
    logout_req = 1'b1;
    tick();
    logout_req = 1'b0;
    tick();

    // Three denials lock out
    for (int k = 0; k < 3; k++) begin
      deny_entry(16'(16'h9870 + k));
      check("locked_after_deny", {31'd0, locked}, {31'd0, (k == 2)});
    end
    lock_n = 1;
    while (lock_n < 2000) begin
      if (lock_n == 10) begin
        digit_in   = 4'h5;
        digit_load = 1'b1;
      end
      tick();
      digit_load = 1'b0;
      if (lock_n == 10) check("count_in_lockout", {29'd0, digit_count}, 32'd0);
      if (!locked) break;
      lock_n++;
    end
    check("lockout_len", lock_n, LO);
    check("after_lockout_leds", {30'd0, led_red, locked}, 32'd0);

    // Responder silent: DENIED exactly TO cycles after SEND
    enter(16'h4444);
    to_n = 0;
    while (to_n < 400) begin
      tick();
      to_n++;
      if (led_red) break;
    end
    check("timeout_len", to_n, TO);
    tick();
    check("timeout_not_locked", {31'd0, locked}, 32'd0);

    // Second consecutive failure still short of lockout
    deny_entry(16'h5555);
    check("two_fails_not_locked", {31'd0, locked}, 32'd0);

    // Reserved status keeps WAIT; a grant then clears the failure count
    enter(16'h2468);
    bus.status_in = 2'b11;
    repeat (5) tick();
    check("reserved_stays_wait", {28'd0, access_granted, led_red, bus.req_out}, 32'b0001);
    bus.status_in = 2'b01;
    tick();
    bus.status_in = 2'b00;
    check("granted_after_reserved", {31'd0, access_granted}, 32'd1);
    do_logout();
    deny_entry(16'h1111);
    check("grant_cleared_fails", {31'd0, locked}, 32'd0);

`ifdef CLEAR_KEY_EN
    exp_q.push_back({2'b01, 16'h5678});
    load_digit(4'h1);
    load_digit(4'h2);
    load_digit(4'hF);
    check("clear_key_count", {29'd0, digit_count}, 32'd0);
    load_digit(4'h5);
    load_digit(4'h6);
    load_digit(4'h7);
    load_digit(4'h8);
`else
    exp_q.push_back({2'b01, 16'h12F5});
    load_digit(4'h1);
    load_digit(4'h2);
    load_digit(4'hF);
    check("f_is_digit_count", {29'd0, digit_count}, 32'd3);
    load_digit(4'h5);
`endif
    check("count_full_f", {29'd0, digit_count}, 32'd4);
    tick();
    tick();
    bus.status_in = 2'b01;
    tick();
    bus.status_in = 2'b00;
    check("granted_before_reset", {31'd0, access_granted}, 32'd1);

    // Reset while granted: everything drops, no LOGOUT frame
    rst = 1'b1;
    tick();
    check("reset_mid_op", {8'd0, access_granted, led_green, led_red, locked, digit_count,
                           bus.req_out, bus.data_out, bus.data_load_out}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
